// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks from the start-bit edge to the middle of the start bit
  function automatic int half_period(input int clocks_per_bit);
    return clocks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture; both stages reset to the line's idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry output buffer, RTS and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 556
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      uart_rts,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_period(CLOCKS_PER_BIT) - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rxd_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (uart_rxd),
    .q  (rxd_s)
  );

  rx_state_t                 state_reg;
  logic [CW-1:0]             cnt_reg;
  logic [2:0]                idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] data_reg;
  logic                      valid_reg;
  logic                      rts_reg;
  logic                      fe_reg;
  logic                      ov_reg;
  logic                      rxd_prev_reg;

  // Frame FSM, bit timing, output buffer and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      rts_reg      <= 1'b0;
      fe_reg       <= 1'b0;
      ov_reg       <= 1'b0;
      rxd_prev_reg <= 1'b1;
    end else begin
      fe_reg       <= 1'b0;
      ov_reg       <= 1'b0;
      rxd_prev_reg <= rxd_s;
      rts_reg      <= valid_reg;

      // A read empties the buffer unless a commit below refills it
      if (valid_reg && rx_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (rxd_prev_reg && !rxd_s) begin
            cnt_reg   <= '0;
            state_reg <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rxd_s) begin
              idx_reg   <= '0;
              state_reg <= ST_DATA;
            end else begin
              // Line went back high before mid-bit: treat as a glitch
              state_reg <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
            if (idx_reg == IDX_LAST) begin
              state_reg <= ST_STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rxd_s) begin
              state_reg <= ST_IDLE;
              if (!valid_reg || rx_ready) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
              end else begin
                ov_reg <= 1'b1;
              end
            end else begin
              fe_reg    <= 1'b1;
              state_reg <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit
          if (rxd_s) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = data_reg;
  assign rx_valid  = valid_reg;
  assign uart_rts  = rts_reg;
  assign frame_err = fe_reg;
  assign overrun   = ov_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int HALF     = CPB / 2;
  // Pin edge to detection: two synchronizer flops plus the edge detector
  localparam int SYNC_LAT = 3;
  // Edge (counted from the pin's start-bit edge) on which a frame commits
  localparam int COMMIT   = SYNC_LAT + HALF + 9 * CPB;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uart_rts;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Reference model of the one-entry buffer
  logic       exp_valid;
  logic [7:0] exp_data;

  // Per-cycle output history of the most recent frame
  logic       hv  [0:FRAME];
  logic [7:0] hd  [0:FRAME];
  logic       hr  [0:FRAME];
  logic       hfe [0:FRAME];
  logic       hov [0:FRAME];

  uart_rx #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .uart_rts (uart_rts),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, rx_valid, 1'b0);
    check({tag, ".rts"}, uart_rts, 1'b0);
    check({tag, ".data"}, rx_data, 8'h00);
    check({tag, ".fe"}, frame_err, 1'b0);
    check({tag, ".ov"}, overrun, 1'b0);
  endtask

  // Drive one frame on the pin; optionally hold rx_ready high for the
  // single cycle that ends at the commit edge. The line is left at the
  // stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ready_commit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    uart_rxd = bits[0];
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      hv[c]  = rx_valid;
      hd[c]  = rx_data;
      hr[c]  = uart_rts;
      hfe[c] = frame_err;
      hov[c] = overrun;
      if (c == COMMIT - 1) rx_ready = ready_commit;
      if (c == COMMIT) rx_ready = 1'b0;
      if (c < FRAME) uart_rxd = bits[c / CPB];
      else uart_rxd = stop_bit;
    end
  endtask

  task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop_bit,
                                 input logic ready_commit);
    logic prev_valid;
    logic efe;
    logic eov;
    int   nfe;
    int   nov;
    prev_valid = exp_valid;
    send_frame(d, stop_bit, ready_commit);
    efe = !stop_bit;
    eov = stop_bit && exp_valid && !ready_commit;
    if (stop_bit) begin
      if (!exp_valid || ready_commit) begin
        exp_valid = 1'b1;
        exp_data  = d;
      end
    end else if (exp_valid && ready_commit) begin
      exp_valid = 1'b0;
    end
    nfe = 0;
    nov = 0;
    for (int c = 1; c <= FRAME; c++) begin
      nfe += int'(hfe[c]);
      nov += int'(hov[c]);
    end
    check({tag, ".valid_before"}, hv[COMMIT-1], prev_valid);
    check({tag, ".valid"}, hv[COMMIT], exp_valid);
    check({tag, ".data"}, hd[COMMIT], exp_data);
    check({tag, ".fe_at_commit"}, hfe[COMMIT], efe);
    check({tag, ".ov_at_commit"}, hov[COMMIT], eov);
    check({tag, ".fe_count"}, nfe, int'(efe));
    check({tag, ".ov_count"}, nov, int'(eov));
    check({tag, ".rts"}, hr[COMMIT+1], exp_valid);
    $display("frame %s: byte=%02h stop=%0b ready=%0b valid=%0b data=%02h fe=%0d ov=%0d",
             tag, d, stop_bit, ready_commit, hv[COMMIT], hd[COMMIT], nfe, nov);
  endtask

  // Consume the buffered byte with a one-cycle rx_ready pulse
  task automatic read_byte(input string tag);
    check({tag, ".rd_valid"}, rx_valid, exp_valid);
    check({tag, ".rd_data"}, rx_data, exp_data);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check({tag, ".rd_cleared"}, rx_valid, 1'b0);
    check({tag, ".rd_rts_lag"}, uart_rts, 1'b1);
    tick();
    check({tag, ".rd_rts_low"}, uart_rts, 1'b0);
    check({tag, ".rd_data_hold"}, rx_data, exp_data);
    exp_valid = 1'b0;
    $display("read %s: data=%02h", tag, rx_data);
  endtask

  // Let the line sit with no frame and confirm nothing happens
  task automatic idle_check(input string tag, input int n);
    int nfe;
    int nov;
    int nbad_valid;
    nfe = 0;
    nov = 0;
    nbad_valid = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      nfe += int'(frame_err);
      nov += int'(overrun);
      if (rx_valid !== exp_valid) nbad_valid++;
    end
    check({tag, ".fe"}, nfe, 0);
    check({tag, ".ov"}, nov, 0);
    check({tag, ".valid"}, nbad_valid, 0);
    $display("idle %s: cycles=%0d fe=%0d ov=%0d valid_dev=%0d", tag, n, nfe, nov, nbad_valid);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rstop;
    logic       rrdy;
    int         gap;

    exp_valid = 1'b0;
    exp_data  = 8'h00;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Basic receive and read
    frame_and_check("a5", 8'hA5, 1'b1, 1'b0);
    check("a5.rts_prev_cycle", hr[COMMIT], 1'b0);
    read_byte("a5");

    // Short glitch is ignored, next byte is fine
    uart_rxd = 1'b0;
    repeat (2) tick();
    uart_rxd = 1'b1;
    idle_check("glitch", 4 * CPB);
    frame_and_check("3c", 8'h3C, 1'b1, 1'b0);
    read_byte("3c");

    // Framing error, then a long break, then recovery
    frame_and_check("55_bad_stop", 8'h55, 1'b0, 1'b0);
    idle_check("break", 20 * CPB);
    uart_rxd = 1'b1;
    idle_check("release", 2 * CPB);
    frame_and_check("01", 8'h01, 1'b1, 1'b0);
    read_byte("01");

    // Overrun: second byte dropped, first kept
    frame_and_check("ov_11", 8'h11, 1'b1, 1'b0);
    frame_and_check("ov_22", 8'h22, 1'b1, 1'b0);
    check("ov.kept_first", rx_data, 8'h11);
    read_byte("ov");

    // Read coinciding with commit replaces the byte without overrun
    frame_and_check("rc_11", 8'h11, 1'b1, 1'b0);
    frame_and_check("rc_22", 8'h22, 1'b1, 1'b1);
    check("rc.replaced", rx_data, 8'h22);
    read_byte("rc");

    // Randomized frames against the buffer model
    for (int i = 0; i < 8; i++) begin
      rd    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rrdy  = 1'($urandom_range(0, 1));
      frame_and_check("rnd", rd, rstop, rrdy);
      if (!rstop) begin
        uart_rxd = 1'b1;
        idle_check("rnd_release", 2 * CPB);
      end else begin
        gap = int'($urandom_range(0, 12));
        if (gap > 0) idle_check("rnd_gap", gap);
      end
      if (exp_valid && ($urandom_range(0, 1) == 1)) read_byte("rnd");
    end

    // Make sure the buffer is occupied before the reset test
    frame_and_check("pre_rst", 8'h5A, 1'b1, 1'b0);

    // Reset during bit 4 of 0xFF
    uart_rxd = 1'b0;
    repeat (CPB) tick();
    uart_rxd = 1'b1;
    repeat (4 * CPB + HALF) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    tick();
    check_reset_outputs("post_rst");
    idle_check("post_rst_idle", 6 * CPB);
    frame_and_check("81", 8'h81, 1'b1, 1'b0);
    read_byte("81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
